// File: rtl/bin_bcd_pkg.sv
// Shared types, constants and sizing helpers for the binary-to-BCD converter.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Nibble value used to fill every digit of an out-of-range result.
  localparam logic [3:0] BCD_ERR_NIBBLE = 4'hF;

  // 10^n as a 64-bit value; valid for n <= 19.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Minimum number of decimal digits needed to show any value of a
  // width-bit unsigned quantity.
  function automatic int bcd_digits_for(input int width);
    longint unsigned maxv;
    int n;
    maxv = (64'd1 << width) - 64'd1;
    n = 1;
    while (pow10(n) <= maxv) n++;
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the nibble is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with a start/busy/done handshake and a range check against MAX_VAL.
module bin_to_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W   = 7,
  parameter int DIGITS  = 3,
  parameter int MAX_VAL = 81
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  // Parameter sanity checks, resolved at elaboration.
  if (DIGITS < 1) begin : g_chk_digits
    $fatal(1, "bin_to_bcd_seq: DIGITS must be at least 1");
  end
  if (longint'(MAX_VAL) > ((longint'(1) << BIN_W) - longint'(1))) begin : g_chk_max
    $fatal(1, "bin_to_bcd_seq: MAX_VAL does not fit in BIN_W bits");
  end
  if (pow10(DIGITS) <= longint'(MAX_VAL)) begin : g_chk_range
    $fatal(1, "bin_to_bcd_seq: DIGITS too small to show MAX_VAL");
  end

  bcd_state_t          state_reg, state_next;
  logic [BIN_W-1:0]    shift_reg, shift_next;
  logic [BCD_W-1:0]    scratch_reg, scratch_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                flag_reg, flag_next;
  logic [BCD_W-1:0]    bcd_reg, bcd_next;
  logic                err_reg, err_next;

  logic [BCD_W-1:0]        scratch_adj;
  logic [BCD_W+BIN_W-1:0]  shifted;

  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch_reg[4*gi +: 4]),
      .adj   (scratch_adj[4*gi +: 4])
    );
  end

  assign shifted = {scratch_adj, shift_reg} << 1;

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      flag_reg    <= 1'b0;
      bcd_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      scratch_reg <= scratch_next;
      cnt_reg     <= cnt_next;
      flag_reg    <= flag_next;
      bcd_reg     <= bcd_next;
      err_reg     <= err_next;
    end
  end

  // Next-state, datapath update and handshake outputs. The result register
  // is loaded on the edge that enters DONE, so it is valid with the pulse.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    scratch_next = scratch_reg;
    cnt_next     = cnt_reg;
    flag_next    = flag_reg;
    bcd_next     = bcd_reg;
    err_next     = err_reg;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next   = bin_in;
          scratch_next = '0;
          cnt_next     = CNT_W'(BIN_W);
          flag_next    = (bin_in > MAX_BIN);
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        busy                     = 1'b1;
        {scratch_next, shift_next} = shifted;
        cnt_next                 = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
          bcd_next   = flag_reg ? {DIGITS{BCD_ERR_NIBBLE}} : shifted[BCD_W+BIN_W-1:BIN_W];
          err_next   = flag_reg;
        end
      end

      DONE: begin
        done = 1'b1;
        if (start) begin
          shift_next   = bin_in;
          scratch_next = '0;
          cnt_next     = CNT_W'(BIN_W);
          flag_next    = (bin_in > MAX_BIN);
          state_next   = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bcd_out = bcd_reg;
  assign err     = err_reg;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
- Replaces fixed lookup-table conversion for wider display values, such as score, product and timer fields, that feed the 7-segment display path.
- One conversion per start request, with a start/busy/done handshake.
- Range check against MAX_VAL; out-of-range inputs produce an all-ones error code.

Parameters:
- BIN_W, 7: width of the binary input.
- DIGITS, 3: number of BCD output digits. bcd_out is 4*DIGITS bits.
- MAX_VAL, 81: largest legal input value. Inputs above it are flagged as errors.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only while busy=0.
- bin_in  input  BIN_W  binary value; sampled in the cycle start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and err are valid from this cycle.
- bcd_out  output  4*DIGITS  result, most significant digit in the top nibble. Holds its value until the next done.
- err  output  1  high with done when the latched input exceeds MAX_VAL. Holds its value like bcd_out.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, err=0, bcd_out=0; internal scratch registers cleared. Reset asserted mid-conversion aborts it, and no done is produced.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: busy=0.
    - start=1 → latch bin_in into the shift register, clear the BCD scratch, load counter=BIN_W, compute the error flag (bin_in > MAX_VAL), go to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - add 3 to every scratch nibble ≥5 (combinational adjust);
    - shift {scratch, shift register} left by 1;
    - decrement the counter.
    - When the counter reaches 1, the current shift is the last one; go to DONE next cycle.
  - DONE: busy=0, done=1 for exactly one cycle.
    - bcd_out ← scratch, or all ones (every nibble 4'hF) if the error flag is set.
    - err ← error flag.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back conversions). Otherwise return to IDLE.
- Latency: start accepted at cycle 0 → done at cycle BIN_W+1, for both legal and error inputs (uniform latency).
- start is ignored while busy=1. bin_in changes after acceptance have no effect.
- Counter width is $clog2(BIN_W+1).
- Elaboration-time checks, fatal on failure:
  - MAX_VAL ≤ 2^BIN_W − 1;
  - 10^DIGITS > MAX_VAL;
  - DIGITS ≥ 1.
- The scratch register is 4*DIGITS bits. A legal input never overflows it, so no saturation logic is needed.

Decomposition:
- Package bin_bcd_pkg:
  - state enum (IDLE, SHIFT, DONE);
  - BCD_ERR_NIBBLE = 4'hF;
  - function bcd_digits_for(width) returning the minimum digit count, used by instantiating blocks.
- Sub-module bcd_digit_adj: combinational 4-bit add-3-if-≥5. Instantiated DIGITS times with a generate loop.

Test Plan:
- Default params, bin_in=0 with start at cycle 0 → busy high cycles 1–7; done at cycle 8 with bcd_out=12'h000, err=0.
- Default params, bin_in=81 → done at cycle 8, bcd_out=12'h081, err=0. Then bin_in=82 → bcd_out=12'hFFF, err=1, same latency.
- Back-to-back: start with 9, then start asserted again in the DONE cycle with 45 → first done shows 12'h009; second done 8 cycles later shows 12'h045. bcd_out holds 12'h009 in between.
- start pulsed with bin_in=63 while busy during a conversion of 27 → ignored; single done with 12'h027; no extra done follows.
- rst asserted at cycle 4 of a conversion of 50 → busy=0, bcd_out=0, no done pulse. A new start of 50 after reset → 12'h050 at +8 cycles.
- BIN_W=10, DIGITS=4, MAX_VAL=999: 999 → done at cycle 11, 16'h0999. 1000 → 16'hFFFF, err=1.
